fpu_unpack_norm: RTL
====================

Name: fpu_unpack_norm

Overview:
- Pipelined, parametrised floating-point unpacker with a valid/ready handshake.
- Classifies each operand and converts it to an unbiased signed exponent.
- Normalises subnormals so the significand MSB is always 1 for nonzero finite values.
- Sits between operand registers and the FPU datapath (add/mul), so downstream logic never handles subnormals or bias.

Parameters:
- EXPONENT_WIDTH, 11, stored exponent field width.
- SIGNIFICAND_WIDTH, 52, stored fraction width without the implied bit.
- TAG_WIDTH, 4, sideband tag passed through unchanged.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_fp  input  1+EXPONENT_WIDTH+SIGNIFICAND_WIDTH  packed operand {sign, exponent, fraction}
- in_daz  input  1  denormals-are-zero mode, sampled with the operand
- in_tag  input  TAG_WIDTH  sideband tag
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_sign  output  1  sign
- out_exp  output  EXPONENT_WIDTH+2  signed unbiased exponent
- out_sig  output  SIGNIFICAND_WIDTH+1  normalised significand
- out_class  output  3  fp_class_t: ZERO, SUBNORMAL, NORMAL, INF, QNAN, SNAN
- out_is_subnormal  output  1  input was subnormal, reported even when DAZ applies
- out_tag  output  TAG_WIDTH  tag

Behaviour:
- Reset: clk and rst as above; rst is synchronous and active-high.
  - All stage valids are cleared and every output register is zeroed, so out_valid=0 and out_class=ZERO.
  - in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-operation discards all in-flight operands.
- Transfers: a transfer occurs on a clk edge where valid and ready are both 1.
- Pipeline: two register stages.
  - S1 registers the unpacked fields, the class, and the leading-zero count lz of the fraction.
  - S2 registers the shifted significand and the adjusted exponent.
  - Latency is 2 cycles from input transfer to out_valid, with throughput 1 per cycle.
- Flow control:
  - S2 loads when !out_valid or out_ready.
  - S1 loads when !s1_valid or S2 loads.
  - in_ready equals the S1 load condition. It is combinational from out_ready, with no path from in_valid.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - No operand is dropped, duplicated or reordered.
- Arithmetic: bias = 2^(EXPONENT_WIDTH-1)-1; let e = stored exponent and f = fraction.
  - NORMAL (0<e<max): out_exp = e-bias, out_sig = {1,f}.
  - SUBNORMAL (e=0, f!=0, daz=0):
    - lz counts leading zeros over the SIGNIFICAND_WIDTH-bit f.
    - out_sig = {0,f} << (lz+1).
    - out_exp = -bias-lz.
  - ZERO (e=0, f=0), or subnormal with daz=1: out_exp = 0, out_sig = 0, class ZERO.
    - out_is_subnormal = 1 in the daz case.
  - INF (e=max, f=0): out_exp = bias+1, out_sig = {1,0}.
  - NaN (e=max, f!=0): out_exp = bias+1, out_sig = {1,f}, payload preserved.
    - QNAN when f[MSB]=1; SNAN otherwise.
- Sign passes through for every class, including -0, NaN and -inf.
- Elaboration-time assertion: SIGNIFICAND_WIDTH < 2^(EXPONENT_WIDTH-1). This guarantees out_exp never overflows its EXPONENT_WIDTH+2 signed range.

Decomposition:
- Package fpu_pkg holds:
  - the fp_class_t enum (3-bit);
  - functions fp_bias(EXPONENT_WIDTH) and fp_width(EXPONENT_WIDTH, SIGNIFICAND_WIDTH);
  - the localparam conventions for field positions.
- One sub-module: fpu_lzc #(WIDTH), a combinational leading-zero counter of width $clog2(WIDTH+1).
  - Outputs WIDTH when the input is all zeros.
  - Instantiated in front of S1.
  - Reusable by the normaliser in the add path.

Test Plan (defaults, double precision; sig values are 53-bit):
1. Single operand 0x3FF0000000000000 (1.0), out_ready=1 → out_valid exactly 2 cycles after transfer; exp=0, sig=0x10000000000000, class NORMAL, sign=0.
2. Operand 0x0000000000000001 with daz=0 → exp=-1074, sig=0x10000000000000, class SUBNORMAL, is_subnormal=1. Same operand with daz=1 → class ZERO, exp=0, sig=0, is_subnormal=1.
3. Specials:
   - 0x7FF0000000000001 → SNAN, exp=1024, sig=0x10000000000001.
   - 0x7FF8000000000000 → QNAN.
   - 0xFFF0000000000000 → INF, sign=1.
   - 0x8000000000000000 → ZERO, sign=1.
4. Backpressure: offer 4 back-to-back operands with tags 1..4; hold out_ready=0 from cycle 2 for 3 cycles.
   - in_ready deasserts once both stages are full.
   - out_* stay bit-stable while stalled.
   - Results then emerge in tag order 1,2,3,4 with no gaps once out_ready=1.
5. Reset mid-stream: with both stages valid, assert rst for 1 cycle → next cycle out_valid=0, in_ready=1, all outputs 0. A new operand afterwards completes with 2-cycle latency.
6. Streaming: 1000 random operands, out_ready toggling randomly → every result matches the golden unpack model, in order.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: operand class encoding and field-layout helpers
// used by the unpacker and the normaliser in the add path.
package fpu_pkg;

    typedef enum logic [2:0] {
        FP_ZERO      = 3'd0,
        FP_SUBNORMAL = 3'd1,
        FP_NORMAL    = 3'd2,
        FP_INF       = 3'd3,
        FP_QNAN      = 3'd4,
        FP_SNAN      = 3'd5
    } fp_class_t;

    // Packed operand layout is {sign, exponent, fraction}, fraction at bit 0.
    localparam int FP_FRAC_LSB = 32'sd0;

    function automatic int fp_bias(input int exponent_width);
        return (32'sd1 <<< (exponent_width - 32'sd1)) - 32'sd1;
    endfunction

    function automatic int fp_width(input int exponent_width, input int significand_width);
        return 32'sd1 + exponent_width + significand_width;
    endfunction

    function automatic int fp_exp_lsb(input int significand_width);
        return FP_FRAC_LSB + significand_width;
    endfunction

    function automatic int fp_sign_pos(input int exponent_width, input int significand_width);
        return fp_exp_lsb(significand_width) + exponent_width;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module fpu_lzc #(
    parameter int WIDTH = 52
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH+1)-1:0] count_o
);

    localparam int CW = $clog2(WIDTH + 1);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            count_o = data_i[i] ? CW'(WIDTH - 1 - i) : count_o;
        end
    end

endmodule

// File: rtl/fpu_unpack_norm.sv
// Two-stage floating-point unpacker: classifies the operand, removes the bias and
// normalises subnormals so downstream datapaths see a leading one on every finite nonzero value.
module fpu_unpack_norm
    import fpu_pkg::*;
#(
    parameter int EXPONENT_WIDTH    = 11,
    parameter int SIGNIFICAND_WIDTH = 52,
    parameter int TAG_WIDTH         = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [fp_width(EXPONENT_WIDTH, SIGNIFICAND_WIDTH)-1:0] in_fp,
    input  logic                                          in_daz,
    input  logic [TAG_WIDTH-1:0]                          in_tag,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          out_sign,
    output logic [EXPONENT_WIDTH+1:0]                     out_exp,
    output logic [SIGNIFICAND_WIDTH:0]                    out_sig,
    output logic [2:0]                                    out_class,
    output logic                                          out_is_subnormal,
    output logic [TAG_WIDTH-1:0]                          out_tag
);

    localparam int EW   = EXPONENT_WIDTH;
    localparam int SW   = SIGNIFICAND_WIDTH;
    localparam int OEW  = EW + 2;
    localparam int LZW  = $clog2(SW + 1);
    localparam int BIAS = fp_bias(EW);
    localparam logic signed [OEW-1:0] BIAS_S    = OEW'(BIAS);
    localparam logic signed [OEW-1:0] EXP_SPEC  = OEW'(BIAS + 1);

    // Keeps the most negative subnormal exponent inside the signed output range.
    if (SW >= (32'sd1 <<< (EW - 32'sd1))) begin : g_width_check
        $error("fpu_unpack_norm: SIGNIFICAND_WIDTH must be below 2^(EXPONENT_WIDTH-1)");
    end

    logic            in_sign_s;
    logic [EW-1:0]   in_exp_s;
    logic [SW-1:0]   in_frac_s;
    logic [LZW-1:0]  in_lz_s;
    fp_class_t       in_class_s;
    logic            in_sub_s;
    logic            s1_load_s;
    logic            s2_load_s;

    logic            s1_valid_q;
    logic            s1_sign_q;
    logic [EW-1:0]   s1_exp_q;
    logic [SW-1:0]   s1_frac_q;
    logic [LZW-1:0]  s1_lz_q;
    fp_class_t       s1_class_q;
    logic            s1_sub_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;

    logic signed [OEW-1:0] out_exp_d;
    logic [SW:0]           out_sig_d;
    logic [LZW-1:0]        shamt_s;

    logic            out_valid_q;
    logic            out_sign_q;
    logic [OEW-1:0]  out_exp_q;
    logic [SW:0]     out_sig_q;
    fp_class_t       out_class_q;
    logic            out_sub_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    assign in_sign_s = in_fp[fp_sign_pos(EW, SW)];
    assign in_exp_s  = in_fp[fp_exp_lsb(SW) +: EW];
    assign in_frac_s = in_fp[FP_FRAC_LSB +: SW];

    assign s2_load_s = !out_valid_q || out_ready;
    assign s1_load_s = !s1_valid_q || s2_load_s;
    assign in_ready  = s1_load_s;

    fpu_lzc #(.WIDTH(SW)) u_lzc (
        .data_i  (in_frac_s),
        .count_o (in_lz_s)
    );

    // Operand classification; DAZ flushes subnormals to zero but still flags them.
    always_comb begin
        in_class_s = FP_NORMAL;
        in_sub_s   = 1'b0;
        if (in_exp_s == {EW{1'b0}}) begin
            if (in_frac_s == {SW{1'b0}}) begin
                in_class_s = FP_ZERO;
            end else if (in_daz) begin
                in_class_s = FP_ZERO;
                in_sub_s   = 1'b1;
            end else begin
                in_class_s = FP_SUBNORMAL;
                in_sub_s   = 1'b1;
            end
        end else if (&in_exp_s) begin
            if (in_frac_s == {SW{1'b0}}) begin
                in_class_s = FP_INF;
            end else if (in_frac_s[SW-1]) begin
                in_class_s = FP_QNAN;
            end else begin
                in_class_s = FP_SNAN;
            end
        end else begin
            in_class_s = FP_NORMAL;
        end
    end

    // Stage 1 register: unpacked fields, class and leading-zero count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= {EW{1'b0}};
            s1_frac_q  <= {SW{1'b0}};
            s1_lz_q    <= {LZW{1'b0}};
            s1_class_q <= FP_ZERO;
            s1_sub_q   <= 1'b0;
            s1_tag_q   <= {TAG_WIDTH{1'b0}};
        end else if (s1_load_s) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q  <= in_sign_s;
                s1_exp_q   <= in_exp_s;
                s1_frac_q  <= in_frac_s;
                s1_lz_q    <= in_lz_s;
                s1_class_q <= in_class_s;
                s1_sub_q   <= in_sub_s;
                s1_tag_q   <= in_tag;
            end
        end
    end

    assign shamt_s = s1_lz_q + {{(LZW-1){1'b0}}, 1'b1};

    // Unbiased exponent and normalised significand per class.
    always_comb begin
        out_exp_d = {OEW{1'b0}};
        out_sig_d = {(SW+1){1'b0}};
        case (s1_class_q)
            FP_NORMAL: begin
                out_exp_d = $signed({2'b00, s1_exp_q}) - BIAS_S;
                out_sig_d = {1'b1, s1_frac_q};
            end
            FP_SUBNORMAL: begin
                out_exp_d = -BIAS_S - $signed({{(OEW-LZW){1'b0}}, s1_lz_q});
                out_sig_d = {1'b0, s1_frac_q} << shamt_s;
            end
            FP_INF: begin
                out_exp_d = EXP_SPEC;
                out_sig_d = {1'b1, {SW{1'b0}}};
            end
            FP_QNAN, FP_SNAN: begin
                out_exp_d = EXP_SPEC;
                out_sig_d = {1'b1, s1_frac_q};
            end
            default: begin
                out_exp_d = {OEW{1'b0}};
                out_sig_d = {(SW+1){1'b0}};
            end
        endcase
    end

    // Stage 2 / output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= {OEW{1'b0}};
            out_sig_q   <= {(SW+1){1'b0}};
            out_class_q <= FP_ZERO;
            out_sub_q   <= 1'b0;
            out_tag_q   <= {TAG_WIDTH{1'b0}};
        end else if (s2_load_s) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sign_q  <= s1_sign_q;
                out_exp_q   <= out_exp_d;
                out_sig_q   <= out_sig_d;
                out_class_q <= s1_class_q;
                out_sub_q   <= s1_sub_q;
                out_tag_q   <= s1_tag_q;
            end
        end
    end

    assign out_valid        = out_valid_q;
    assign out_sign         = out_sign_q;
    assign out_exp          = out_exp_q;
    assign out_sig          = out_sig_q;
    assign out_class        = out_class_q;
    assign out_is_subnormal = out_sub_q;
    assign out_tag          = out_tag_q;

endmodule
